wb_trace_serializer: RTL and testbench
======================================

Name: wb_trace_serializer

Overview:
- Sits between the dual-issue CPU writeback stage and the single-port debug writeback interface (debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata).
- Accepts up to two retired register writes per cycle, lane 0 older than lane 1.
- Buffers them in program order and replays exactly one write per cycle, so single-port trace comparison works against the golden trace.
- Raises a stall request toward the CPU before the buffer can overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- STALL_MARGIN, 2, free-entry threshold below which stall_o is asserted.

Ports:
- clock  in  1  core clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb0_en  in  1  lane 0 write valid.
- wb0_rd  in  5  lane 0 destination register.
- wb0_data  in  32  lane 0 write data.
- wb0_pc  in  32  lane 0 instruction PC.
- wb1_en, wb1_rd, wb1_data, wb1_pc  in  1/5/32/32  lane 1, same meanings as lane 0.
- stall_o  out  1  request CPU to hold writeback.
- overflow_o  out  1  sticky; an entry was dropped.
- debug_wb_pc  out  32  PC of the emitted write.
- debug_wb_rf_wen  out  4  4'hf when a write is emitted this cycle, else 4'h0.
- debug_wb_rf_wnum  out  5  emitted destination register.
- debug_wb_rf_wdata  out  32  emitted write data.

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous and active-high.
- Reset values: all outputs 0; FIFO empty; count 0; overflow_o 0. Reset mid-operation discards all buffered entries at the next edge.
- Filtering: a lane is pushed only if en=1 and rd!=0. Writes to r0 are never emitted.
- Push order: when both lanes qualify in one cycle, lane 0 is written before lane 1. Order is never swapped.
- Pop: at each edge, if count>0 (count sampled before this edge's pushes), the head is moved into the output registers and wen=4'hf. Otherwise wen=4'h0, and pc/wnum/wdata hold their last emitted values.
- Latency: with an empty FIFO and input presented before edge E, lane 0 is visible after edge E+1 and lane 1 after E+2. There is no bypass.
- Count update: count_next = count - pop + pushes_accepted. Pop and push in the same cycle are legal at any occupancy, including full.
- Space rule: free = DEPTH - count + pop. Entries are accepted in order while free remains.
  - If two qualify and free==1: lane 0 is accepted, lane 1 is dropped.
  - If free==0: both are dropped.
  - Any drop sets overflow_o, which stays set until reset.
- stall_o: combinational, = (DEPTH - count) < STALL_MARGIN + 2.
  - Guarantees two pushes fit for one cycle after the CPU observes the stall.
  - Deasserts as soon as count falls back below the threshold.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits. Full means count==DEPTH.
- Drain: no consumer backpressure. Output drains one entry per cycle unconditionally.

Optional Feature:
- Macro: WB_TRACE_EXC_FILTER_EN.
- Defined: a lane whose pc[31:3] == EXC_VEC_PC[31:3] (EXC_VEC_PC = 32'hbfc00380) is not pushed. These are exception-entry writes that the golden trace does not model.
- Undefined: no PC filtering; only the en/rd rule applies.

Decomposition:
- Package wb_trace_pkg:
  - typedef wb_entry_t packed {pc[31:0], rd[4:0], wdata[31:0]};
  - localparam EXC_VEC_PC;
  - localparam DEBUG_WEN_ALL = 4'hf.
- Sub-module wb_trace_fifo: 2-write/1-read synchronous FIFO of wb_entry_t with in-order dual push, count output and accepted-push count.
- Top level holds lane filtering, the stall/overflow logic and the output registers.

Test Plan:
- Reset held 3 cycles, then both lanes valid with rd=3 / data=0x11, pc=0xbfc00000 and rd=4 / data=0x22, pc=0xbfc00004 -> wnum 3 with wen=f at edge E+1, then wnum 4 at E+2, then wen=0 with pc held at 0xbfc00004.
- Lane 0 rd=0 and lane 1 rd=7 in the same cycle -> only the rd=7 write is emitted; count never exceeds 1.
- DEPTH=16, both lanes valid every cycle with stall_o ignored -> stall_o rises when count reaches 13; first drop sets overflow_o=1, which stays 1 for the rest of the test.
- Same as above but the bench honours stall_o -> overflow_o stays 0, and all emitted PCs are strictly in program order (lane 0 before lane 1).
- Mid-stream reset with count=9 -> next cycle wen=0, pc=0, stall_o=0; the next push emits after one cycle as from empty.
- With WB_TRACE_EXC_FILTER_EN, lane 0 pc=0xbfc00384 rd=26 -> not emitted; without the macro -> emitted with wnum=26.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace serializer.
// Optional exception-vector filtering is enabled with WB_TRACE_EXC_FILTER_EN.
package wb_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_entry_t;

  localparam logic [31:0] EXC_VEC_PC    = 32'hbfc00380;
  localparam logic [3:0]  DEBUG_WEN_ALL = 4'hf;

  // Exception-entry writes share the 8-byte aligned block at the vector.
  function automatic logic is_exc_vec(input logic [31:0] pc);
    return pc[31:3] == EXC_VEC_PC[31:3];
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Two-write / one-read FIFO of trace entries with in-order dual push.
// Slot 0 is always written before slot 1; slot 1 is only taken when two entries fit.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push0_valid,
  input  wb_entry_t                push0_entry,
  input  logic                     push1_valid,
  input  wb_entry_t                push1_entry,
  input  logic                     pop_req,
  output logic                     pop_valid,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               accepted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   free;
  logic            accept0;
  logic            accept1;

  // The slot being popped this edge is reusable by this edge's pushes.
  assign pop_valid = pop_req && (count != '0);
  assign free      = CW'(DEPTH) - count + CW'(pop_valid);
  assign accept0   = push0_valid && (free != '0);
  assign accept1   = push1_valid && accept0 && (free >= CW'(2));
  assign accepted  = {1'b0, accept0} + {1'b0, accept1};
  assign head      = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (accept0) begin
      mem[wr_ptr] <= push0_entry;
    end
    if (accept1) begin
      mem[wr_ptr + AW'(1)] <= push1_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(accepted);
      rd_ptr <= rd_ptr + AW'(pop_valid);
      count  <= count - CW'(pop_valid) + CW'(accepted);
    end
  end

endmodule

// File: rtl/wb_trace_serializer.sv
// Serializes up to two retired register writes per cycle onto the single-port debug trace.
// Define WB_TRACE_EXC_FILTER_EN to drop writes whose PC lies in the exception-vector block.
module wb_trace_serializer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  input  logic [31:0] wb1_pc,
  output logic        stall_o,
  output logic        overflow_o,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t       entry0;
  wb_entry_t       entry1;
  wb_entry_t       first_entry;
  wb_entry_t       head;
  logic            exc0;
  logic            exc1;
  logic            qual0;
  logic            qual1;
  logic            first_valid;
  logic            second_valid;
  logic            pop_valid;
  logic [1:0]      requested;
  logic [1:0]      accepted;
  logic [CW-1:0]   count;
  logic            drop;

`ifdef WB_TRACE_EXC_FILTER_EN
  assign exc0 = is_exc_vec(wb0_pc);
  assign exc1 = is_exc_vec(wb1_pc);
`else
  assign exc0 = 1'b0;
  assign exc1 = 1'b0;
`endif

  assign entry0 = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_data};
  assign entry1 = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_data};

  assign qual0 = wb0_en && (wb0_rd != 5'd0) && !exc0;
  assign qual1 = wb1_en && (wb1_rd != 5'd0) && !exc1;

  // A lone lane-1 write moves into slot 0 so the FIFO only ever sees packed pushes.
  assign first_valid  = qual0 || qual1;
  assign first_entry  = qual0 ? entry0 : entry1;
  assign second_valid = qual0 && qual1;

  assign requested = {1'b0, qual0} + {1'b0, qual1};
  assign drop      = accepted < requested;

  assign stall_o = (DEPTH - int'(count)) < (STALL_MARGIN + 2);

  wb_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push0_valid (first_valid),
    .push0_entry (first_entry),
    .push1_valid (second_valid),
    .push1_entry (entry1),
    .pop_req     (1'b1),
    .pop_valid   (pop_valid),
    .head        (head),
    .count       (count),
    .accepted    (accepted)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_o        <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      overflow_o <= overflow_o || drop;
      if (pop_valid) begin
        debug_wb_pc       <= head.pc;
        debug_wb_rf_wen   <= DEBUG_WEN_ALL;
        debug_wb_rf_wnum  <= head.rd;
        debug_wb_rf_wdata <= head.wdata;
      end else begin
        debug_wb_rf_wen   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Self-checking bench for wb_trace_serializer against a queue-based program-order model.
module tb_wb_trace_serializer;

  localparam int DEPTH        = 16;
  localparam int STALL_MARGIN = 2;
  localparam logic [31:0] EXC_PC = 32'hbfc00380;
`ifdef WB_TRACE_EXC_FILTER_EN
  localparam bit EXC_FILTER = 1'b1;
`else
  localparam bit EXC_FILTER = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb0_en, wb1_en;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data, wb0_pc, wb1_pc;
  logic        stall_o, overflow_o;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  ent_t        model_q[$];
  logic [31:0] exp_pc;
  logic [4:0]  exp_wnum;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wen;
  logic        exp_ovf;
  int          vectors;
  int          miscompares;
  logic [31:0] pc_ctr;
  logic [31:0] last_emit;
  bit          order_chk;

  always #5 clock = ~clock;

  wb_trace_serializer #(
    .DEPTH        (DEPTH),
    .STALL_MARGIN (STALL_MARGIN)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .wb0_en            (wb0_en),
    .wb0_rd            (wb0_rd),
    .wb0_data          (wb0_data),
    .wb0_pc            (wb0_pc),
    .wb1_en            (wb1_en),
    .wb1_rd            (wb1_rd),
    .wb1_data          (wb1_data),
    .wb1_pc            (wb1_pc),
    .stall_o           (stall_o),
    .overflow_o        (overflow_o),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit qualifies(input logic en, input logic [4:0] rd, input logic [31:0] pc);
    bit is_exc;
    is_exc = (pc >> 3) == (EXC_PC >> 3);
    return en && (rd != 5'd0) && !(EXC_FILTER && is_exc);
  endfunction

  function automatic bit model_stall();
    return (DEPTH - model_q.size()) < (STALL_MARGIN + 2);
  endfunction

  task automatic checkOutput();
    check("wen", 32'(debug_wb_rf_wen), 32'(exp_wen));
    check("pc", debug_wb_pc, exp_pc);
    check("wnum", 32'(debug_wb_rf_wnum), 32'(exp_wnum));
    check("wdata", debug_wb_rf_wdata, exp_wdata);
    check("overflow", 32'(overflow_o), 32'(exp_ovf));
    if (order_chk && exp_wen == 4'hf) begin
      check("pc_order", 32'(debug_wb_pc > last_emit), 32'd1);
      last_emit = exp_pc;
    end
  endtask

  // Drive one cycle of lanes from a negedge, advance one clock, then compare.
  task automatic applyStimulus(input logic e0, input logic [4:0] r0, input logic [31:0] d0,
                               input logic [31:0] p0, input logic e1, input logic [4:0] r1,
                               input logic [31:0] d1, input logic [31:0] p1);
    int free;
    ent_t e;
    wb0_en = e0; wb0_rd = r0; wb0_data = d0; wb0_pc = p0;
    wb1_en = e1; wb1_rd = r1; wb1_data = d1; wb1_pc = p1;
    #1;
    check("stall", 32'(stall_o), 32'(model_stall()));
    if (model_q.size() > 0) begin
      e = model_q.pop_front();
      exp_pc = e.pc; exp_wnum = e.rd; exp_wdata = e.data; exp_wen = 4'hf;
    end else begin
      exp_wen = 4'h0;
    end
    free = DEPTH - model_q.size();
    if (qualifies(e0, r0, p0)) begin
      if (free > 0) begin
        model_q.push_back('{pc: p0, rd: r0, data: d0});
        free--;
      end else exp_ovf = 1'b1;
    end
    if (qualifies(e1, r1, p1)) begin
      if (free > 0) begin
        model_q.push_back('{pc: p1, rd: r1, data: d1});
        free--;
      end else exp_ovf = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    wb0_en = 0; wb0_rd = 0; wb0_data = 0; wb0_pc = 0;
    wb1_en = 0; wb1_rd = 0; wb1_data = 0; wb1_pc = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    model_q.delete();
    exp_pc = 0; exp_wnum = 0; exp_wdata = 0; exp_wen = 0; exp_ovf = 0;
    reset = 1'b0;
    #1;
    check("reset_stall", 32'(stall_o), 32'd0);
    checkOutput();
  endtask

  task automatic pushPair();
    applyStimulus(1, 5'(pc_ctr[6:2] | 5'd1), $urandom, pc_ctr,
                  1, 5'(pc_ctr[6:2] | 5'd2), $urandom, pc_ctr + 32'd4);
    pc_ctr += 32'd8;
  endtask

  initial begin
    vectors = 0; miscompares = 0; order_chk = 0; last_emit = 0;
    pc_ctr = 32'h8000_1000;
    applyReset(3);

    // Directed dual-lane ordering and latency.
    applyStimulus(1, 3, 32'h11, 32'hbfc00000, 1, 4, 32'h22, 32'hbfc00004);
    check("dir_e0_wen", 32'(debug_wb_rf_wen), 32'h0);
    idle(1);
    check("dir_e1_wnum", 32'(debug_wb_rf_wnum), 32'd3);
    check("dir_e1_wen", 32'(debug_wb_rf_wen), 32'hf);
    idle(1);
    check("dir_e2_wnum", 32'(debug_wb_rf_wnum), 32'd4);
    idle(1);
    check("dir_e3_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("dir_e3_pc_hold", debug_wb_pc, 32'hbfc00004);

    // r0 on lane 0 is filtered; lane 1 still emitted.
    applyStimulus(1, 0, 32'h33, 32'h8000_0000, 1, 7, 32'h77, 32'h8000_0004);
    idle(2);

    // Exception-vector PC: filtered only when the feature macro is defined.
    applyStimulus(1, 26, 32'h5a5a, 32'hbfc00384, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic, occasionally targeting r0.
    for (int i = 0; i < 200; i++) begin
      logic [4:0] r0, r1;
      r0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus($urandom_range(0, 3) != 0, r0, $urandom, pc_ctr,
                    $urandom_range(0, 3) != 0, r1, $urandom, pc_ctr + 32'd4);
      pc_ctr += 32'd8;
    end
    idle(DEPTH + 2);

    // Ignore stall: FIFO fills, drops occur, overflow sticks.
    applyReset(1);
    for (int i = 0; i < 30; i++) pushPair();
    idle(DEPTH + 4);
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Honour stall: no drops, strictly ascending emitted PCs.
    applyReset(1);
    order_chk = 1; last_emit = 0;
    for (int i = 0; i < 60; i++) begin
      if (model_stall()) idle(1);
      else pushPair();
    end
    idle(DEPTH + 2);
    order_chk = 0;
    check("no_ovf_when_stalled", 32'(overflow_o), 32'd0);

    // Mid-stream reset at occupancy 9, then restart from empty.
    applyReset(1);
    for (int i = 0; i < 8; i++) pushPair();
    check("model_count9", 32'(model_q.size()), 32'd9);
    applyReset(1);
    check("mid_reset_wen", 32'(debug_wb_rf_wen), 32'h0);
    check("mid_reset_pc", debug_wb_pc, 32'h0);
    applyStimulus(1, 9, 32'h99, 32'h9000_0000, 0, 0, 0, 0);
    idle(1);
    check("after_reset_wnum", 32'(debug_wb_rf_wnum), 32'd9);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
